// File: rtl/sc_arb_ctrl.sv
// rtl/sc_arb_ctrl.sv - round-robin arbiter/sequencer sharing one saturating counter
module sc_arb_ctrl #(
    parameter int          NREQ    = 4,
    parameter logic [2:0]  SAT_VAL = 3'd5,
    parameter logic [3:0]  TIMEOUT = 4'd15
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NREQ-1:0] req,
    input  logic [2:0]      sc_out,
    input  logic            sc_err,
    input  logic            clr_fault,
    output logic [NREQ-1:0] gnt,
    output logic [NREQ-1:0] done,
    output logic            done_err,
    output logic            sc_ctr_rst,
    output logic            busy,
    output logic            fault
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_RUN,
        S_DONE,
        S_ERR
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [PW-1:0]   owner;
    logic [PW-1:0]   ptr;
    logic [PW-1:0]   pick;
    logic            any_req;
    logic [3:0]      timer;

    function automatic logic [PW-1:0] rr_idx(input logic [PW-1:0] p, input int off);
        int s;
        s = int'(p) + off;
        return PW'(s % NREQ);
    endfunction

    // Walk from the farthest slot back to ptr+1 so the nearest pending requester wins.
    always_comb begin
        pick    = '0;
        any_req = 1'b0;
        for (int i = NREQ; i >= 1; i--) begin
            if (req[rr_idx(ptr, i)]) begin
                pick    = rr_idx(ptr, i);
                any_req = 1'b1;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (any_req) state_nxt = S_CLEAR;
            S_CLEAR: state_nxt = S_RUN;
            S_RUN: begin
                if (!req[owner])                        state_nxt = S_IDLE;
                else if (sc_err || (timer == TIMEOUT))  state_nxt = S_ERR;
                else if (sc_out == SAT_VAL)             state_nxt = S_DONE;
            end
            S_DONE:  state_nxt = S_IDLE;
            S_ERR:   state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        gnt  = '0;
        done = '0;
        if (state != S_IDLE) gnt[owner] = 1'b1;
        if ((state == S_DONE) || (state == S_ERR)) done[owner] = 1'b1;
        done_err   = (state == S_ERR);
        sc_ctr_rst = (state != S_RUN);
        busy       = (state != S_IDLE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
            owner <= '0;
            ptr   <= PW'(NREQ - 1);
            timer <= 4'd0;
            fault <= 1'b0;
        end else begin
            state <= state_nxt;
            case (state)
                S_IDLE:  if (any_req) owner <= pick;
                S_CLEAR: timer <= 4'd0;
                S_RUN: begin
                    if (timer != 4'hF) timer <= timer + 4'd1;
                    if (!req[owner])   ptr <= owner;
                end
                S_DONE:  ptr <= owner;
                S_ERR:   ptr <= owner;
                default: ;
            endcase
            // A new error outranks a simultaneous clear request.
            if (state == S_ERR)  fault <= 1'b1;
            else if (clr_fault)  fault <= 1'b0;
        end
    end

endmodule

// File: tb/tb_sc_arb_ctrl.sv
// tb/tb_sc_arb_ctrl.sv - scoreboard bench for sc_arb_ctrl
module tb_sc_arb_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] req;
    logic [2:0] sc_out;
    logic       sc_err;
    logic       clr_fault;
    logic [3:0] gnt;
    logic [3:0] done;
    logic       done_err;
    logic       sc_ctr_rst;
    logic       busy;
    logic       fault;

    logic [2:0] cnt = 3'd0;
    logic       stuck = 1'b0;
    int         cyc = 0;
    int         checks = 0;
    int         errors = 0;

    typedef struct {
        int         cyc;
        logic [3:0] d;
        logic       e;
    } exp_t;

    exp_t q[$];
    exp_t m_e;

    sc_arb_ctrl #(.NREQ(4), .SAT_VAL(3'd5), .TIMEOUT(4'd15)) dut (
        .clk(clk), .rst(rst), .req(req), .sc_out(sc_out), .sc_err(sc_err),
        .clr_fault(clr_fault), .gnt(gnt), .done(done), .done_err(done_err),
        .sc_ctr_rst(sc_ctr_rst), .busy(busy), .fault(fault)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Environment model of the shared counter: clears on ctr_rst, saturates at 5.
    always @(posedge clk) begin
        if (sc_ctr_rst)     cnt <= 3'd0;
        else if (cnt != 3'd5) cnt <= cnt + 3'd1;
    end
    assign sc_out = stuck ? 3'd2 : cnt;

    always @(negedge clk) begin
        if (rst && (done !== 4'b0000)) begin
            checks++;
            if (q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_done cyc=%0d done=%b err=%b", cyc, done, done_err);
            end else begin
                m_e = q.pop_front();
                if (done !== m_e.d || done_err !== m_e.e || cyc != m_e.cyc) begin
                    errors++;
                    $display("FAIL done_evt got cyc=%0d done=%b err=%b want cyc=%0d done=%b err=%b",
                             cyc, done, done_err, m_e.cyc, m_e.d, m_e.e);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h (cyc %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push(input int c, input logic [3:0] d, input logic e);
        exp_t x;
        x.cyc = c;
        x.d   = d;
        x.e   = e;
        q.push_back(x);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1 rst = 1'b0;
        #3 rst = 1'b1;
        step(1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int t0;
        int t1;
        rst = 1'b0; req = 4'b0; sc_err = 1'b0; clr_fault = 1'b0;
        #12;
        chk("rst_gnt", gnt, 4'b0000);
        chk("rst_done", done, 4'b0000);
        chk("rst_done_err", done_err, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_fault", fault, 1'b0);
        chk("rst_ctr_rst", sc_ctr_rst, 1'b1);
        step(1);
        rst = 1'b1;
        step(1);

        // single request
        t0 = cyc; req = 4'b0001; push(t0 + 8, 4'b0001, 1'b0);
        step(1);
        chk("t1_gnt_clear", gnt, 4'b0001);
        chk("t1_ctr_rst_clear", sc_ctr_rst, 1'b1);
        chk("t1_busy", busy, 1'b1);
        step(1);
        chk("t1_ctr_rst_run_first", sc_ctr_rst, 1'b0);
        step(5);
        chk("t1_ctr_rst_run_last", sc_ctr_rst, 1'b0);
        step(1);
        req = 4'b0;
        step(1);
        chk("t1_busy_after", busy, 1'b0);
        chk("t1_gnt_after", gnt, 4'b0000);

        // round robin with all requesters pending
        do_reset();
        t0 = cyc; req = 4'b1111;
        push(t0 + 8,  4'b0001, 1'b0);
        push(t0 + 17, 4'b0010, 1'b0);
        push(t0 + 26, 4'b0100, 1'b0);
        push(t0 + 35, 4'b1000, 1'b0);
        push(t0 + 44, 4'b0001, 1'b0);
        step(1);
        for (int k = 0; k < 5; k++) begin
            logic [3:0] eg;
            eg = 4'b0001 << (k % 4);
            chk("rr_gnt", gnt, eg);
            if (k < 4) step(9);
        end
        step(7);
        req = 4'b0;
        step(2);

        // timeout with counter stuck at 2
        do_reset();
        t0 = cyc; stuck = 1'b1; req = 4'b0001; push(t0 + 18, 4'b0001, 1'b1);
        step(17);
        chk("to_still_run", sc_ctr_rst, 1'b0);
        step(1);
        req = 4'b0;
        step(1);
        chk("to_fault_set", fault, 1'b1);
        chk("to_busy", busy, 1'b0);
        step(3);
        chk("to_fault_sticky", fault, 1'b1);
        clr_fault = 1'b1;
        step(1);
        chk("to_fault_clr", fault, 1'b0);
        clr_fault = 1'b0; stuck = 1'b0;

        // sc_err in the third RUN cycle, then next requester served
        do_reset();
        t0 = cyc; req = 4'b0011; push(t0 + 5, 4'b0001, 1'b1);
        step(4);
        sc_err = 1'b1;
        step(1);
        sc_err = 1'b0;
        push(t0 + 14, 4'b0010, 1'b0);
        step(1);
        chk("se_fault", fault, 1'b1);
        chk("se_idle", busy, 1'b0);
        step(1);
        chk("se_next_gnt", gnt, 4'b0010);
        step(7);
        req = 4'b0; clr_fault = 1'b1;
        step(1);
        clr_fault = 1'b0;
        chk("se_fault_clr", fault, 1'b0);

        // abort by dropping req in the second RUN cycle
        do_reset();
        t0 = cyc; req = 4'b0100;
        step(3);
        req = 4'b0000;
        step(1);
        chk("ab_busy", busy, 1'b0);
        chk("ab_ctr_rst", sc_ctr_rst, 1'b1);
        chk("ab_gnt", gnt, 4'b0000);
        req = 4'b0101; push(cyc + 8, 4'b0001, 1'b0);
        step(1);
        chk("ab_next_gnt", gnt, 4'b0001);
        step(7);
        req = 4'b0;
        step(2);

        // async reset mid-RUN
        do_reset();
        req = 4'b0010;
        step(3);
        #3 rst = 1'b0;
        #1;
        chk("ar_gnt", gnt, 4'b0000);
        chk("ar_busy", busy, 1'b0);
        chk("ar_ctr_rst", sc_ctr_rst, 1'b1);
        req = 4'b1000;
        @(posedge clk);
        #1 rst = 1'b1;
        t1 = cyc; push(t1 + 8, 4'b1000, 1'b0);
        step(1);
        chk("ar_gnt_after", gnt, 4'b1000);
        step(7);
        req = 4'b0;
        step(3);

        chk("queue_empty", q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sc_arb_ctrl.md
Name: sc_arb_ctrl

Overview:
Round-robin arbiter and sequencer that shares one saturating counter (3-bit, clears on ctr_rst, counts up every cycle, saturates at SAT_VAL) among NREQ requesters. It grants one requester at a time and clears the counter for that requester. It then watches the counter until it saturates and returns a one-cycle completion pulse. It also times out and reports faults when the counter misbehaves.

Parameters:
NREQ, 4, number of requesters (2..8)
SAT_VAL, 5, counter value that marks completion (3-bit)
TIMEOUT, 15, maximum RUN cycles before timeout fault (4-bit timer)

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  asynchronous, active-low reset (0 = reset)
req  input  NREQ  per-requester request, level, held until done or abort
sc_out  input  3  counter current value
sc_err  input  1  counter error flag
clr_fault  input  1  synchronous clear of sticky fault
gnt  output  NREQ  one-hot grant, asserted in CLEAR, RUN and DONE/ERR
done  output  NREQ  one-hot one-cycle completion pulse
done_err  output  1  qualifies done pulse as failed (timeout/sc_err)
sc_ctr_rst  output  1  counter clear, drives counter ctr_rst
busy  output  1  state != IDLE
fault  output  1  sticky error flag

Behaviour:
- Reset (rst=0, async): state=IDLE, pointer=NREQ-1 (so requester 0 has first priority), timer=0, gnt=0, done=0, done_err=0, busy=0, fault=0, sc_ctr_rst=1.
- FSM states are IDLE, CLEAR, RUN, DONE and ERR. All outputs are registered or decoded from state only; none are combinational from req.
- IDLE: sc_ctr_rst=1, so the counter is held at 0. If any req is high, pick the first requester after the pointer in round-robin order, latch it as owner, and go to CLEAR.
- CLEAR (1 cycle): gnt[owner]=1, sc_ctr_rst=1, timer cleared. Go to RUN.
- RUN: gnt[owner]=1, sc_ctr_rst=0, timer increments each cycle.
  - Priority 1: if req[owner] drops, abort. Go to IDLE with no done pulse; pointer=owner.
  - Priority 2: if sc_err=1 or timer==TIMEOUT, go to ERR.
  - Priority 3: if sc_out==SAT_VAL, go to DONE.
- DONE (1 cycle): gnt[owner]=1, done[owner]=1, done_err=0, sc_ctr_rst=1, pointer=owner. Go to IDLE.
- ERR (1 cycle): gnt[owner]=1, done[owner]=1, done_err=1, fault<=1, sc_ctr_rst=1, pointer=owner. Go to IDLE.
- fault is sticky. It clears only on reset or clr_fault=1. If clr_fault and a new error occur in the same cycle, fault stays 1.
- There is always one IDLE bubble between grants; no back-to-back CLEAR.
- Nominal latency: req rises in cycle 0 (IDLE) → CLEAR in cycle 1 → RUN in cycles 2..7 (sc_out reads 0,1,2,3,4,5) → DONE, done pulse, in cycle 8.
- Fairness: the just-served owner becomes lowest priority. With all req high, the grant order is 0,1,2,3,0,...
- Changes on req of non-owners are ignored while busy.
- Timer is 4 bits and saturates; it never wraps.
- An async reset mid-operation drops gnt/done immediately and asserts sc_ctr_rst.
- In IDLE, a req[owner] that is still high after done is treated as a new request. It only wins when no other requester is pending.

Test Plan:
- Single request: req=0001 held → gnt=0001 in cycle 1, sc_ctr_rst=0 in cycles 2..7, done=0001 with done_err=0 in cycle 8, busy=0 in cycle 9.
- Round-robin: req=1111 held → grant sequence 0001,0010,0100,1000,0001. Each done has a 9-cycle spacing (8 active cycles plus 1 IDLE).
- Timeout: sc_out stuck at 2 → ERR after 15 RUN cycles. done[owner]=1 and done_err=1, fault=1 and stays 1. clr_fault=1 → fault=0 on the next cycle.
- sc_err: assert sc_err in the 3rd RUN cycle → ERR on the next cycle, done_err=1, fault=1. The next grant goes to the following requester.
- Abort: req=0100 dropped in the 2nd RUN cycle → IDLE with no done pulse and sc_ctr_rst=1. Then req=0101 → gnt=0001 (pointer was at 2, so index 0 wins next).
- Async reset: rst=0 mid-RUN, between clock edges → gnt=0, busy=0, sc_ctr_rst=1 immediately. After release with req=1000 → gnt=0001 is not issued; gnt=1000.
